mdu_ctrl: RTL

Iterative multiply/divide controller for the MIPS execute stage. It runs the HI/LO instructions that the single-cycle ALU cannot: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sequences a radix-2 shift-add / restoring-divide datapath over 32 iterations and owns the architectural HI/LO registers. It raises busy so hazard logic stalls any MFHI/MFLO or a new MDU op until the result lands.

---
 rtl/mdu_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl : iterative multiply/divide controller for the MIPS execute stage.
//
// Runs MULT, MULTU, DIV, DIVU (32 iterations of shift-add / restoring divide
// on operand magnitudes, with a final sign fix) and MTHI / MTLO (single-cycle
// writes). It owns the architectural HI/LO registers.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   launch request, only looked at while idle
//   op      in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   a       in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b       in   rt operand (multiplier / divisor)
//   cancel  in   pipeline flush, aborts any in-flight op without writing
//   busy    out  high whenever the controller is not idle
//   done    out  one-cycle pulse when HI/LO take a MULT/DIV result
//   hi, lo  out  architectural HI / LO registers
// ---------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t      state_q;
    logic        busy_q, done_q;
    logic        is_div_q;
    logic        neg_a_q, neg_b_q;
    logic [31:0] a_q;          // raw dividend, kept for the divide-by-zero result
    logic [31:0] ma_q, mb_q;   // operand magnitudes (ma shifts for div, mb for mult)
    logic [63:0] acc_q;        // mult: product; div: {remainder, quotient}
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;

    // One iteration of the datapath and the final sign-corrected results.
    logic [32:0] rem_sh, rem_sub;
    logic        rem_ge;
    logic [63:0] acc_d;
    logic        sgn;
    logic [63:0] prod_d;
    logic [31:0] quo_d, rem_d;
    logic [31:0] abs_a_d, abs_b_d;

    always_comb begin
        rem_sh  = {acc_q[63:32], ma_q[31]};
        rem_sub = rem_sh - {1'b0, mb_q};
        rem_ge  = (rem_sh >= {1'b0, mb_q});
        if (is_div_q) begin
            acc_d = {(rem_ge ? rem_sub[31:0] : rem_sh[31:0]), acc_q[30:0], rem_ge};
        end else begin
            acc_d = {acc_q[62:0], 1'b0} + (mb_q[31] ? {32'd0, ma_q} : 64'd0);
        end

        // Two's-complement negation of 0x8000_0000 yields 0x8000_0000, which is
        // exactly the unsigned magnitude we need.
        abs_a_d = neg_a_q ? (32'd0 - ma_q) : ma_q;
        abs_b_d = neg_b_q ? (32'd0 - mb_q) : mb_q;

        sgn    = neg_a_q ^ neg_b_q;
        prod_d = sgn ? (64'd0 - acc_q) : acc_q;
        quo_d  = sgn ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        // Remainder takes the dividend's sign.
        rem_d  = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            a_q      <= 32'd0;
            ma_q     <= 32'd0;
            mb_q     <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                state_q  <= PREP;
                                busy_q   <= 1'b1;
                                is_div_q <= op[1];
                                // op[0] set means unsigned: no sign handling.
                                neg_a_q  <= ~op[0] & a[31];
                                neg_b_q  <= ~op[0] & b[31];
                                a_q      <= a;
                                ma_q     <= a;
                                mb_q     <= b;
                            end
                            3'd4:    hi_q <= a;
                            3'd5:    lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                PREP: begin
                    if (cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ma_q    <= abs_a_d;
                        mb_q    <= abs_b_d;
                        acc_q   <= 64'd0;
                        cnt_q   <= 5'd0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        if (is_div_q) ma_q <= {ma_q[30:0], 1'b0};
                        else          mb_q <= {mb_q[30:0], 1'b0};
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(ITER - 1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            hi_q <= prod_d[63:32];
                            lo_q <= prod_d[31:0];
                        end else if (mb_q == 32'd0) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            hi_q <= a_q;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= rem_d;
                            lo_q <= quo_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
